shift_arbiter: RTL and testbench

- Shares one 32-bit shift datapath (SLL/SRL/SRA) between two requesters, e.g. the ALU issue path and a CSR/debug path.
- Round-robin arbitration with valid/ready handshakes on both request ports.
- Registers each result and holds it on a single response port tagged with the requester id until the consumer accepts it.
- Internally uses the team's combinational left-logical shifter; right shifts are built in-block.

---
 rtl/shift_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_shift_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_arbiter.sv
// -----------------------------------------------------------------------------
// shift_arbiter
//   Shares one 32-bit shift datapath (SLL/SRL/SRA) between two requesters.
//   Round-robin arbitration on valid/ready request ports. The result is
//   registered and held on a single response port, tagged with the requester
//   id, until the consumer accepts it.
//
//   Build option: define SHIFT_ARB_FIXED_PRIO_EN for fixed priority
//   (requester 0 always wins a tie). When it is undefined the block uses
//   round-robin arbitration.
//
// Ports
//   i_clk                 clock, rising edge
//   i_reset               synchronous active-high reset
//   i_reqN_valid          requester N has an operation (N = 0, 1)
//   i_reqN_data/amt/op    operand, shift amount, op (00 SLL, 01 SRL, 10 SRA, 11 -> 0)
//   o_reqN_ready          requester N accepted this cycle (IDLE only)
//   o_rsp_valid           result available
//   o_rsp_data            shift result
//   o_rsp_id              requester that issued the result
//   i_rsp_ready           consumer takes the result
// -----------------------------------------------------------------------------

// Combinational left-logical shifter shared with other blocks.
module shift_sll #(
    parameter int DATA_W = 32,
    parameter int AMT_W  = 5
) (
    input  logic [DATA_W-1:0] i_data,
    input  logic [AMT_W-1:0]  i_amt,
    output logic [DATA_W-1:0] o_data
);
    assign o_data = i_data << i_amt;
endmodule

// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | arbitrate; ready asserted for the granted requester
// EXEC  | compute from latched operands, register result and id
// DONE  | o_rsp_valid=1, result held until i_rsp_ready
module shift_arbiter #(
    parameter int DATA_W = 32,
    parameter int AMT_W  = 5
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_req0_valid,
    input  logic [DATA_W-1:0] i_req0_data,
    input  logic [AMT_W-1:0]  i_req0_amt,
    input  logic [1:0]        i_req0_op,
    output logic              o_req0_ready,
    input  logic              i_req1_valid,
    input  logic [DATA_W-1:0] i_req1_data,
    input  logic [AMT_W-1:0]  i_req1_amt,
    input  logic [1:0]        i_req1_op,
    output logic              o_req1_ready,
    output logic              o_rsp_valid,
    output logic [DATA_W-1:0] o_rsp_data,
    output logic              o_rsp_id,
    input  logic              i_rsp_ready
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [DATA_W-1:0] r_data;
    logic [AMT_W-1:0]  r_amt;
    logic [1:0]        r_op;
    logic              r_id;
    logic              w_grant_id;
    logic              w_hs;
    logic [DATA_W-1:0] w_sll;
    logic [DATA_W-1:0] w_srl;
    logic [DATA_W-1:0] w_sra;
    logic [DATA_W-1:0] w_result;

`ifndef SHIFT_ARB_FIXED_PRIO_EN
    logic              r_last_grant;
`endif

    // Requester selection; only meaningful when at least one is valid.
    always_comb begin
        w_grant_id = 1'b0;
        if (i_req0_valid && i_req1_valid) begin
`ifdef SHIFT_ARB_FIXED_PRIO_EN
            w_grant_id = 1'b0;
`else
            w_grant_id = ~r_last_grant;
`endif
        end else if (i_req1_valid) begin
            w_grant_id = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_hs         = 1'b0;
        o_req0_ready = 1'b0;
        o_req1_ready = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_req0_valid || i_req1_valid) begin
                    w_hs         = 1'b1;
                    o_req0_ready = ~w_grant_id;
                    o_req1_ready = w_grant_id;
                    w_next       = S_EXEC;
                end
            end
            S_EXEC: w_next = S_DONE;
            S_DONE: begin
                if (i_rsp_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
        // A reset cycle must not look like an accepted request.
        if (i_reset) begin
            w_hs         = 1'b0;
            o_req0_ready = 1'b0;
            o_req1_ready = 1'b0;
        end
    end

    shift_sll #(.DATA_W(DATA_W), .AMT_W(AMT_W)) u_sll (
        .i_data (r_data),
        .i_amt  (r_amt),
        .o_data (w_sll)
    );

    assign w_srl = r_data >> r_amt;
    assign w_sra = DATA_W'($signed(r_data) >>> r_amt);

    always_comb begin
        case (r_op)
            2'b00:   w_result = w_sll;
            2'b01:   w_result = w_srl;
            2'b10:   w_result = w_sra;
            default: w_result = '0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_data       <= '0;
            r_amt        <= '0;
            r_op         <= 2'b00;
            r_id         <= 1'b0;
            o_rsp_data   <= '0;
            o_rsp_id     <= 1'b0;
`ifndef SHIFT_ARB_FIXED_PRIO_EN
            r_last_grant <= 1'b1;
`endif
        end else begin
            if (w_hs) begin
                r_data       <= w_grant_id ? i_req1_data : i_req0_data;
                r_amt        <= w_grant_id ? i_req1_amt  : i_req0_amt;
                r_op         <= w_grant_id ? i_req1_op   : i_req0_op;
                r_id         <= w_grant_id;
`ifndef SHIFT_ARB_FIXED_PRIO_EN
                r_last_grant <= w_grant_id;
`endif
            end
            if (r_state == S_EXEC) begin
                o_rsp_data <= w_result;
                o_rsp_id   <= r_id;
            end
        end
    end

    assign o_rsp_valid = (r_state == S_DONE);

endmodule

// File: tb/tb_shift_arbiter.sv
module tb_shift_arbiter;

    logic        clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        v0 = 1'b0, v1 = 1'b0;
    logic [31:0] d0 = '0, d1 = '0;
    logic [4:0]  a0 = '0, a1 = '0;
    logic [1:0]  op0 = '0, op1 = '0;
    logic        r0, r1;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_id;
    logic        rsp_ready = 1'b1;

    always #5 clk = ~clk;

    shift_arbiter dut (
        .i_clk        (clk),
        .i_reset      (i_reset),
        .i_req0_valid (v0),
        .i_req0_data  (d0),
        .i_req0_amt   (a0),
        .i_req0_op    (op0),
        .o_req0_ready (r0),
        .i_req1_valid (v1),
        .i_req1_data  (d1),
        .i_req1_amt   (a1),
        .i_req1_op    (op1),
        .o_req1_ready (r1),
        .o_rsp_valid  (rsp_valid),
        .o_rsp_data   (rsp_data),
        .o_rsp_id     (rsp_id),
        .i_rsp_ready  (rsp_ready)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Shift result from plain arithmetic: multiply/divide by 2**amt.
    function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [31:0] d, input int amt);
        longint unsigned p, x, y;
        logic [31:0] nd;
        p = 1;
        for (int k = 0; k < amt; k++) p = p * 2;
        x  = longint'(d) & 64'hFFFF_FFFF;
        nd = ~d;
        y  = longint'(nd) & 64'hFFFF_FFFF;
        case (op)
            2'b00:   return 32'((x * p) % 64'h1_0000_0000);
            2'b01:   return 32'(x / p);
            2'b10:   return d[31] ? ~32'(y / p) : 32'(x / p);
            default: return 32'h0;
        endcase
    endfunction

    // Transaction-level reference: one op outstanding at a time, result
    // visible two cycles after the accept, held until consumed.
    bit          m_busy = 0;
    int          m_cnt  = 0;
    bit          m_last = 1;
    logic [31:0] m_exp_data;
    bit          m_exp_id;
    int          cyc = 0;
    int          grants[$];
    int          hs_cyc[$];
    int          rsp_cyc = 0;
    int          rsp_count = 0;
    logic [31:0] last_rsp_data;
    bit          last_rsp_id;

    task automatic step();
        int  gid;
        bit  exp_valid;
        @(negedge clk);
        cyc++;
        gid = -1;
        if (m_busy) m_cnt++;
        if (!m_busy && !i_reset) begin
            if (v0 && v1) begin
`ifdef SHIFT_ARB_FIXED_PRIO_EN
                gid = 0;
`else
                gid = m_last ? 0 : 1;
`endif
            end else if (v0) gid = 0;
            else if (v1) gid = 1;
        end
        chk("ready0", 32'(r0), 32'(gid == 0));
        chk("ready1", 32'(r1), 32'(gid == 1));
        exp_valid = m_busy && (m_cnt >= 2);
        chk("rsp_valid", 32'(rsp_valid), 32'(exp_valid));
        if (exp_valid) begin
            chk("rsp_data", rsp_data, m_exp_data);
            chk("rsp_id", 32'(rsp_id), 32'(m_exp_id));
        end
        if (i_reset) begin
            m_busy = 0;
            m_cnt  = 0;
            m_last = 1;
        end else if (gid >= 0) begin
            m_busy     = 1;
            m_cnt      = 0;
            m_exp_id   = (gid == 1);
            m_exp_data = (gid == 1) ? ref_shift(op1, d1, int'(a1)) : ref_shift(op0, d0, int'(a0));
            m_last     = (gid == 1);
            grants.push_back(gid);
            hs_cyc.push_back(cyc);
        end else if (exp_valid && rsp_ready) begin
            m_busy        = 0;
            rsp_count++;
            rsp_cyc       = cyc;
            last_rsp_data = rsp_data;
            last_rsp_id   = rsp_id;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        v0 = 0; v1 = 0; rsp_ready = 1;
        n = 0;
        while (m_busy && n < 10) begin
            step();
            n++;
        end
        if (m_busy) chk("drain_timeout", 32'(m_busy), 32'd0);
    endtask

    task automatic do_reset();
        i_reset = 1;
        step();
        step();
        i_reset = 0;
    endtask

    typedef struct {
        bit          id;
        logic [1:0]  op;
        logic [31:0] data;
        logic [4:0]  amt;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int n, base, rc;

        vecs.push_back('{1'b0, 2'b00, 32'h0000_0001, 5'd4,  32'h0000_0010});
        vecs.push_back('{1'b1, 2'b10, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF});
        vecs.push_back('{1'b1, 2'b01, 32'h8000_0000, 5'd31, 32'h0000_0001});
        vecs.push_back('{1'b1, 2'b11, 32'h8000_0000, 5'd31, 32'h0000_0000});
        vecs.push_back('{1'b0, 2'b00, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF});
        vecs.push_back('{1'b0, 2'b01, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF});
        vecs.push_back('{1'b1, 2'b10, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF});
        vecs.push_back('{1'b0, 2'b00, 32'hDEAD_BEEF, 5'd31, 32'h8000_0000});
        vecs.push_back('{1'b1, 2'b10, 32'hF000_0000, 5'd4,  32'hFF00_0000});
        vecs.push_back('{1'b0, 2'b10, 32'h7FFF_0000, 5'd4,  32'h07FF_F000});

        do_reset();
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_data", rsp_data, 32'h0);
        chk("reset_rsp_id", 32'(rsp_id), 32'd0);
        chk("reset_ready0", 32'(r0), 32'd0);

        // Table vectors through a single requester each.
        foreach (vecs[i]) begin
            rc = rsp_count;
            base = grants.size();
            if (vecs[i].id) begin
                v1 = 1; d1 = vecs[i].data; a1 = vecs[i].amt; op1 = vecs[i].op;
            end else begin
                v0 = 1; d0 = vecs[i].data; a0 = vecs[i].amt; op0 = vecs[i].op;
            end
            rsp_ready = 1;
            n = 0;
            while (rsp_count == rc && n < 20) begin
                step();
                if (grants.size() != base) begin
                    v0 = 0; v1 = 0;
                end
                n++;
            end
            if (rsp_count == rc) chk("vec_timeout", 32'(n), 32'd0);
            else begin
                chk("vec_data", last_rsp_data, vecs[i].exp);
                chk("vec_id", 32'(last_rsp_id), 32'(vecs[i].id));
                chk("vec_latency", 32'(rsp_cyc - hs_cyc[$]), 32'd2);
            end
        end
        drain();

        // Continuous tie, four ops, consumer always ready.
        do_reset();
        base = grants.size();
        v0 = 1; v1 = 1; op0 = 2'b00; op1 = 2'b01;
        d0 = 32'h0000_00F0; d1 = 32'h0F00_0000; a0 = 5'd3; a1 = 5'd7;
        n = 0;
        while (grants.size() < base + 4 && n < 40) begin
            step();
            n++;
        end
        if (grants.size() < base + 4) chk("tie_timeout", 32'(grants.size() - base), 32'd4);
        else begin
            for (int i = 0; i < 4; i++) begin
`ifdef SHIFT_ARB_FIXED_PRIO_EN
                chk("tie_grant", 32'(grants[base+i]), 32'd0);
`else
                chk("tie_grant", 32'(grants[base+i]), 32'(i % 2));
`endif
                if (i > 0) chk("tie_spacing", 32'(hs_cyc[base+i] - hs_cyc[base+i-1]), 32'd3);
            end
        end
        drain();

        // Consumer stalls for several cycles in DONE.
        base = grants.size();
        v0 = 1; v1 = 0; op0 = 2'b01; d0 = 32'hF0F0_0000; a0 = 5'd8; rsp_ready = 0;
        n = 0;
        while (grants.size() == base && n < 10) begin
            step();
            n++;
        end
        v0 = 0; v1 = 1; op1 = 2'b00; d1 = 32'h0000_0003; a1 = 5'd1;
        for (int i = 0; i < 7; i++) step();
        chk("stall_valid", 32'(rsp_valid), 32'd1);
        chk("stall_no_accept", 32'(grants.size()), 32'(base + 1));
        rsp_ready = 1;
        step();
        step();
        chk("stall_accept_next", 32'(hs_cyc[$] - rsp_cyc), 32'd1);
        chk("stall_accept_id", 32'(grants[$]), 32'd1);
        drain();

        // Reset while in EXEC.
        base = grants.size();
        v0 = 1; v1 = 0; op0 = 2'b00; d0 = 32'h1234_5678; a0 = 5'd2;
        n = 0;
        while (grants.size() == base && n < 10) begin
            step();
            n++;
        end
        v0 = 0;
        i_reset = 1;
        step();
        i_reset = 0;
        chk("rst_exec_valid", 32'(rsp_valid), 32'd0);
        chk("rst_exec_data", rsp_data, 32'h0);
        v0 = 1; v1 = 1;
        step();
        chk("rst_tie_grant", 32'(grants[$]), 32'd0);
        drain();

        // Randomized traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            v0  = 1'($urandom_range(0, 1));
            v1  = 1'($urandom_range(0, 1));
            d0  = $urandom;
            d1  = $urandom;
            a0  = 5'($urandom_range(0, 31));
            a1  = 5'($urandom_range(0, 31));
            op0 = 2'($urandom_range(0, 3));
            op1 = 2'($urandom_range(0, 3));
            rsp_ready = ($urandom_range(0, 9) < 7);
            step();
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
